// File: rtl/wb_stream_dbg_master_pkg.sv
// -----------------------------------------------------------------------------
// wb_stream_dbg_master_pkg
//   Shared definitions for the byte-stream debug Wishbone master:
//   command opcodes, response status codes, FSM state encoding and the
//   byte-select expansion helper.
// -----------------------------------------------------------------------------
package wb_stream_dbg_master_pkg;

   // Command opcodes carried in cmd[7:4]
   localparam logic [3:0] OP_WRITE = 4'h1;
   localparam logic [3:0] OP_READ  = 4'h2;

   // Response status bytes
   localparam logic [7:0] ST_OK      = 8'hA0;
   localparam logic [7:0] ST_ERR     = 8'hE0;
   localparam logic [7:0] ST_BADOP   = 8'hE1;
   localparam logic [7:0] ST_TIMEOUT = 8'hE2;
   localparam logic [7:0] ST_RTY     = 8'hE3;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_BUS  = 3'd3,
      S_RSP  = 3'd4
   } state_t;

   // A zero select field in the command byte means "all four bytes".
   function automatic logic [3:0] expand_sel(input logic [3:0] sel);
      return (sel == 4'h0) ? 4'hF : sel;
   endfunction

endpackage

// File: rtl/wb_stream_dbg_master.sv
// -----------------------------------------------------------------------------
// wb_stream_dbg_master
//   Debug Wishbone classic initiator driven by a host byte stream. Commands
//   (WRITE: cmd + 4 address + 4 data bytes, READ: cmd + 4 address bytes, all
//   MSB first) are decoded into one single Wishbone cycle; a status byte
//   (plus 4 read-data bytes for a successful READ) is returned on the
//   response stream.
//
//   Optional feature macro: WB_DBG_TIMEOUT_EN
//     defined   -> a bus cycle with no ack/err/rty for TIMEOUT_CYCLES cycles
//                  is abandoned and reported with status 0xE2.
//     undefined -> the bus cycle waits indefinitely for termination.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cmd_data_i/valid_i/ready_o   host command byte stream (valid/ready)
//   rsp_data_o/valid_o/ready_i   response byte stream (valid/ready)
//   wbm_*                        Wishbone classic master port
// -----------------------------------------------------------------------------
module wb_stream_dbg_master
   import wb_stream_dbg_master_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [7:0]            cmd_data_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   output logic [7:0]            rsp_data_o,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [ADDR_WIDTH-1:0] wbm_adr_o,
   output logic [31:0]           wbm_dat_o,
   input  logic [31:0]           wbm_dat_i,
   output logic [3:0]            wbm_sel_o,
   output logic                  wbm_we_o,
   output logic                  wbm_cyc_o,
   output logic                  wbm_stb_o,
   input  logic                  wbm_ack_i,
   input  logic                  wbm_err_i,
   input  logic                  wbm_rty_i
);

   if (ADDR_WIDTH < 1 || ADDR_WIDTH > 32 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("wb_stream_dbg_master: ADDR_WIDTH must be 1..32 and TIMEOUT_CYCLES >= 1");
   end

   state_t      state;
   logic [1:0]  byte_cnt;
   logic        is_read;
   logic [2:0]  rsp_left;     // read-data bytes still to send after the current one
   logic [23:0] shift_sr;     // first three bytes of the address or data word
   logic [31:0] rd_sr;        // captured read data, drained MSB first
`ifdef WB_DBG_TIMEOUT_EN
   logic [31:0] tmo_cnt;
`endif

   logic        cmd_fire;
   logic [31:0] word_full;    // completed 32-bit word once the 4th byte arrives
   logic [3:0]  cmd_op;

   assign cmd_fire  = cmd_valid_i & cmd_ready_o;
   assign word_full = {shift_sr, cmd_data_i};
   assign cmd_op    = cmd_data_i[7:4];

   // Address/data/read-data shift registers carry no reset: they are only
   // observed after being fully reloaded by a new command or bus cycle.
   always_ff @(posedge clk_i) begin
      if (cmd_fire && (state == S_ADDR || state == S_DATA))
         shift_sr <= {shift_sr[15:0], cmd_data_i};
      if (state == S_BUS && wbm_ack_i)
         rd_sr <= wbm_dat_i;
      else if (state == S_RSP && rsp_ready_i && rsp_left != 3'd0)
         rd_sr <= {rd_sr[23:0], 8'h00};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         cmd_ready_o <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_data_o  <= 8'h00;
         wbm_adr_o   <= '0;
         wbm_dat_o   <= 32'h0;
         wbm_sel_o   <= 4'h0;
         wbm_we_o    <= 1'b0;
         wbm_cyc_o   <= 1'b0;
         wbm_stb_o   <= 1'b0;
         byte_cnt    <= 2'd0;
         is_read     <= 1'b0;
         rsp_left    <= 3'd0;
`ifdef WB_DBG_TIMEOUT_EN
         tmo_cnt     <= 32'd0;
`endif
      end else begin
`ifdef WB_DBG_TIMEOUT_EN
         // Counter is zero on the first BUS cycle and counts BUS cycles.
         tmo_cnt <= (state == S_BUS) ? tmo_cnt + 32'd1 : 32'd0;
`endif
         case (state)
            S_IDLE: begin
               cmd_ready_o <= 1'b1;
               if (cmd_fire) begin
                  byte_cnt <= 2'd0;
                  if (cmd_op == OP_WRITE || cmd_op == OP_READ) begin
                     is_read   <= (cmd_op == OP_READ);
                     wbm_sel_o <= expand_sel(cmd_data_i[3:0]);
                     state     <= S_ADDR;
                  end else begin
                     rsp_data_o  <= ST_BADOP;
                     rsp_valid_o <= 1'b1;
                     rsp_left    <= 3'd0;
                     cmd_ready_o <= 1'b0;
                     state       <= S_RSP;
                  end
               end
            end

            S_ADDR: begin
               if (cmd_fire) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     // Address is latched now for both commands; it is only
                     // qualified once cyc rises.
                     wbm_adr_o <= word_full[ADDR_WIDTH-1:0];
                     if (is_read) begin
                        wbm_we_o    <= 1'b0;
                        wbm_cyc_o   <= 1'b1;
                        wbm_stb_o   <= 1'b1;
                        cmd_ready_o <= 1'b0;
                        state       <= S_BUS;
                     end else begin
                        state <= S_DATA;
                     end
                  end
               end
            end

            S_DATA: begin
               if (cmd_fire) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     wbm_dat_o   <= word_full;
                     wbm_we_o    <= 1'b1;
                     wbm_cyc_o   <= 1'b1;
                     wbm_stb_o   <= 1'b1;
                     cmd_ready_o <= 1'b0;
                     state       <= S_BUS;
                  end
               end
            end

            S_BUS: begin
               // ack has priority over err, err over rty.
               if (wbm_ack_i || wbm_err_i || wbm_rty_i) begin
                  wbm_cyc_o   <= 1'b0;
                  wbm_stb_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  state       <= S_RSP;
                  if (wbm_ack_i) begin
                     rsp_data_o <= ST_OK;
                     rsp_left   <= is_read ? 3'd4 : 3'd0;
                  end else if (wbm_err_i) begin
                     rsp_data_o <= ST_ERR;
                     rsp_left   <= 3'd0;
                  end else begin
                     rsp_data_o <= ST_RTY;
                     rsp_left   <= 3'd0;
                  end
               end
`ifdef WB_DBG_TIMEOUT_EN
               else if (tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                  wbm_cyc_o   <= 1'b0;
                  wbm_stb_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_data_o  <= ST_TIMEOUT;
                  rsp_left    <= 3'd0;
                  state       <= S_RSP;
               end
`endif
            end

            S_RSP: begin
               if (rsp_ready_i) begin
                  if (rsp_left == 3'd0) begin
                     rsp_valid_o <= 1'b0;
                     cmd_ready_o <= 1'b1;
                     state       <= S_IDLE;
                  end else begin
                     rsp_data_o <= rd_sr[31:24];
                     rsp_left   <= rsp_left - 3'd1;
                  end
               end
            end

            default: begin
               state       <= S_IDLE;
               cmd_ready_o <= 1'b0;
               rsp_valid_o <= 1'b0;
               wbm_cyc_o   <= 1'b0;
               wbm_stb_o   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_stream_dbg_master.sv
// -----------------------------------------------------------------------------
// tb_wb_stream_dbg_master
//   Self-checking bench: host byte driver, Wishbone slave with configurable
//   wait/termination, and a reference model deriving expected response bytes
//   and bus fields from the command frame.
// -----------------------------------------------------------------------------
module tb_wb_stream_dbg_master;

   localparam int AW  = 32;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic [7:0]    cmd_data_i = 8'h00;
   logic          cmd_valid_i = 1'b0;
   logic          cmd_ready_o;
   logic [7:0]    rsp_data_o;
   logic          rsp_valid_o;
   logic          rsp_ready_i = 1'b0;
   logic [AW-1:0] wbm_adr_o;
   logic [31:0]   wbm_dat_o;
   logic [31:0]   wbm_dat_i = 32'h0;
   logic [3:0]    wbm_sel_o;
   logic          wbm_we_o;
   logic          wbm_cyc_o;
   logic          wbm_stb_o;
   logic          wbm_ack_i = 1'b0;
   logic          wbm_err_i = 1'b0;
   logic          wbm_rty_i = 1'b0;

   wb_stream_dbg_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .cmd_data_i(cmd_data_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
      .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o),
      .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
      .wbm_rty_i(wbm_rty_i)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Slave behaviour: 0 ack, 1 err, 2 rty, 3 silent
   int          s_mode = 0;
   int          s_wait = 0;
   logic [31:0] s_rdata = 32'h0;

   // Monitor state
   int          wcnt = 0;
   int          cyc_total = 0;
   int          unstable = 0;
   int          stb_bad = 0;
   logic        prev_cyc = 1'b0;
   logic [AW-1:0] cap_adr = '0;
   logic [31:0] cap_dat = 32'h0;
   logic [3:0]  cap_sel = 4'h0;
   logic        cap_we = 1'b0;

   logic [7:0]  rx_q[$];
   logic [7:0]  exp_q[$];

   // Slave responder and bus monitor, sampled on the falling edge.
   always @(negedge clk) begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_rty_i = 1'b0;
      wbm_dat_i = ~s_rdata;
      if (wbm_stb_o !== wbm_cyc_o) stb_bad++;
      if (wbm_cyc_o === 1'b1) begin
         cyc_total++;
         if (prev_cyc && (wbm_adr_o !== cap_adr || wbm_dat_o !== cap_dat ||
                          wbm_sel_o !== cap_sel || wbm_we_o !== cap_we))
            unstable++;
         cap_adr = wbm_adr_o;
         cap_dat = wbm_dat_o;
         cap_sel = wbm_sel_o;
         cap_we  = wbm_we_o;
         if (s_mode != 3 && wcnt == s_wait) begin
            case (s_mode)
               0: wbm_ack_i = 1'b1;
               1: wbm_err_i = 1'b1;
               default: wbm_rty_i = 1'b1;
            endcase
            wbm_dat_i = s_rdata;
         end
         wcnt++;
      end else begin
         wcnt = 0;
      end
      prev_cyc = (wbm_cyc_o === 1'b1);
   end

   // Present one command byte; returns at the falling edge after acceptance.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      cmd_valid_i = 1'b1;
      cmd_data_i  = b;
      while (cmd_ready_o !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (cmd_ready_o !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL send_byte: ready never seen for byte %02h (waited %0d cycles)", b, n);
      end else begin
         @(negedge clk);
      end
      cmd_valid_i = 1'b0;
   endtask

   task automatic recv_bytes(input int n, input bit rnd);
      int t = 0;
      rx_q.delete();
      while (rx_q.size() < n && t < 1000) begin
         rsp_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (rsp_valid_o === 1'b1 && rsp_ready_i) rx_q.push_back(rsp_data_o);
         @(negedge clk);
         t++;
      end
      checks++;
      if (rx_q.size() != n) begin
         errors++;
         $display("FAIL rsp_count: got %0d bytes, required %0d", rx_q.size(), n);
      end else begin
         checks++;
         if (cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: cmd_ready=%b after last rsp byte, required 1", cmd_ready_o);
         end
      end
      rsp_ready_i = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rsp_extra: rsp_valid=%b data=%02h after response, required valid 0",
                     rsp_valid_o, rsp_data_o);
         end
      end
      rsp_ready_i = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
   endtask

   // Reference model + one full transaction with checks.
   task automatic do_txn(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                         input int mode, input int wt, input logic [31:0] rdata, input bit rnd,
                         input string tag);
      logic [3:0] op;
      bit         valid_op;
      bit         is_wr;
      int         c0;
      int         u0;
      int         sb0;
      op       = cmd[7:4];
      valid_op = (op == 4'h1 || op == 4'h2);
      is_wr    = (op == 4'h1);
      exp_q.delete();
      if (!valid_op) exp_q.push_back(8'hE1);
      else begin
         case (mode)
            0: begin
               exp_q.push_back(8'hA0);
               if (!is_wr)
                  for (int i = 3; i >= 0; i--) exp_q.push_back(8'((rdata >> (8 * i)) & 32'hFF));
            end
            1: exp_q.push_back(8'hE0);
            2: exp_q.push_back(8'hE3);
            default: exp_q.push_back(8'hE2);
         endcase
      end
      s_mode  = mode;
      s_wait  = wt;
      s_rdata = rdata;
      c0  = cyc_total;
      u0  = unstable;
      sb0 = stb_bad;
      send_byte(cmd);
      if (valid_op) begin
         for (int i = 3; i >= 0; i--) send_byte(8'((addr >> (8 * i)) & 32'hFF));
         if (is_wr)
            for (int i = 3; i >= 0; i--) send_byte(8'((data >> (8 * i)) & 32'hFF));
      end
      recv_bytes(exp_q.size(), rnd);
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         checks++;
         if (rx_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s rsp_byte[%0d]: got %02h, required %02h", tag, i, rx_q[i], exp_q[i]);
         end
      end
      checks++;
      if (!valid_op) begin
         if (cyc_total != c0) begin
            errors++;
            $display("FAIL %s no_bus: cyc high %0d cycles, required 0", tag, cyc_total - c0);
         end
      end else begin
         if (cyc_total - c0 != ((mode == 3) ? TMO : wt + 1)) begin
            errors++;
            $display("FAIL %s cyc_len: cyc high %0d cycles, required %0d", tag, cyc_total - c0,
                     (mode == 3) ? TMO : wt + 1);
         end
         checks++;
         if (cap_adr !== addr[AW-1:0] || cap_we !== is_wr ||
             cap_sel !== ((cmd[3:0] == 4'h0) ? 4'hF : cmd[3:0])) begin
            errors++;
            $display("FAIL %s bus_ctl: adr=%08h we=%b sel=%h, required adr=%08h we=%b sel=%h", tag,
                     cap_adr, cap_we, cap_sel, addr[AW-1:0], is_wr,
                     (cmd[3:0] == 4'h0) ? 4'hF : cmd[3:0]);
         end
         if (is_wr) begin
            checks++;
            if (cap_dat !== data) begin
               errors++;
               $display("FAIL %s bus_dat: dat=%08h, required %08h", tag, cap_dat, data);
            end
         end
      end
      checks++;
      if (unstable != u0 || stb_bad != sb0) begin
         errors++;
         $display("FAIL %s bus_stable: unstable=%0d stb_mismatch=%0d, required 0 new", tag,
                  unstable - u0, stb_bad - sb0);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b, required 0", cmd_ready_o); end
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid_o); end
      checks++; if (rsp_data_o !== 8'h00) begin errors++; $display("FAIL reset_rsp_data: got %02h, required 00", rsp_data_o); end
      checks++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin errors++; $display("FAIL reset_cyc_stb: got %b%b, required 00", wbm_cyc_o, wbm_stb_o); end
      checks++; if (wbm_adr_o !== '0 || wbm_dat_o !== 32'h0) begin errors++; $display("FAIL reset_adr_dat: got %08h %08h, required 0 0", wbm_adr_o, wbm_dat_o); end
      checks++; if (wbm_sel_o !== 4'h0 || wbm_we_o !== 1'b0) begin errors++; $display("FAIL reset_sel_we: got %h %b, required 0 0", wbm_sel_o, wbm_we_o); end
      rst_i = 1'b0;
      @(negedge clk);
      checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b, required 1", cmd_ready_o); end
   endtask

   task automatic test_write();
      do_txn(8'h1F, 32'h0000_0010, 32'hDEAD_BEEF, 0, 2, 32'h0, 1'b0, "write_dir");
   endtask

   task automatic test_read();
      do_txn(8'h20, 32'h0000_0004, 32'h0, 0, 1, 32'h1234_5678, 1'b1, "read_dir");
   endtask

   task automatic test_bad_opcode();
      do_txn(8'h30, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0, "bad_op");
      do_txn(8'h23, 32'h0000_0100, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b0, "read_after_bad");
   endtask

   task automatic test_err_rty();
      do_txn(8'h20, 32'h0000_0008, 32'h0, 1, 0, 32'h1111_2222, 1'b0, "read_err");
      do_txn(8'h20, 32'h0000_000C, 32'h0, 2, 0, 32'h3333_4444, 1'b0, "read_rty");
      do_txn(8'h15, 32'h0000_0020, 32'h5555_6666, 1, 3, 32'h0, 1'b1, "write_err");
   endtask

   task automatic test_timeout();
`ifdef WB_DBG_TIMEOUT_EN
      do_txn(8'h20, 32'h0000_0040, 32'h0, 3, 0, 32'h0, 1'b0, "timeout");
`else
      int c0;
      s_mode = 3;
      c0 = cyc_total;
      send_byte(8'h20);
      for (int i = 0; i < 4; i++) send_byte(8'h00);
      repeat (40) @(negedge clk);
      checks++;
      if (wbm_cyc_o !== 1'b1 || cyc_total - c0 < 40) begin
         errors++;
         $display("FAIL no_timeout_cyc: cyc=%b high %0d cycles, required still high", wbm_cyc_o, cyc_total - c0);
      end
      checks++;
      if (rsp_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL no_timeout_rsp: rsp_valid=%b, required 0", rsp_valid_o);
      end
      pulse_reset();
      checks++;
      if (wbm_cyc_o !== 1'b0) begin
         errors++;
         $display("FAIL no_timeout_recover: cyc=%b after reset, required 0", wbm_cyc_o);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int n = 0;
      s_mode = 3;
      send_byte(8'h20);
      for (int i = 0; i < 4; i++) send_byte(8'h00);
      while (wbm_cyc_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      pulse_reset();
      checks++;
      if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_bus: cyc=%b stb=%b rsp_valid=%b, required 0 0 0", wbm_cyc_o, wbm_stb_o, rsp_valid_o);
      end
      send_byte(8'h20);
      send_byte(8'hAA);
      send_byte(8'hBB);
      pulse_reset();
      checks++;
      if (wbm_cyc_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_frame: cyc=%b rsp_valid=%b, required 0 0", wbm_cyc_o, rsp_valid_o);
      end
      do_txn(8'h20, 32'h0000_0044, 32'h0, 0, 0, 32'h89AB_CDEF, 1'b0, "read_after_rst");
   endtask

   task automatic test_random();
      for (int k = 0; k < 25; k++) begin
         int          r;
         logic [7:0]  cmd;
         logic [3:0]  nib;
         r = $urandom_range(0, 9);
         if (r < 4) nib = 4'h1;
         else if (r < 9) nib = 4'h2;
         else nib = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(3, 15));
         cmd = {nib, 4'($urandom_range(0, 15))};
         do_txn(cmd, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 3),
                $urandom, 1'($urandom_range(0, 1)), "random");
      end
   endtask

   task automatic test_back_to_back();
      do_txn(8'h2F, 32'h0000_0080, 32'h0, 0, 0, 32'h0102_0304, 1'b0, "b2b_1");
      do_txn(8'h1C, 32'h0000_0084, 32'hA5A5_5A5A, 0, 0, 32'h0, 1'b0, "b2b_2");
      do_txn(8'h21, 32'h0000_0088, 32'h0, 0, 0, 32'hFFFF_0000, 1'b0, "b2b_3");
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_bad_opcode();
      test_err_rty();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
